// File: rtl/kb_rx_ctrl_if.sv
// kb_rx_ctrl_if -- receiver handshake and key-event bundle for kb_rx_ctrl.
// master: the sequencing controller. slave: the frame receiver / key consumer side.
interface kb_rx_ctrl_if;
   logic       i_byte_en;
   logic [7:0] i_byte;
   logic       o_recv_en;
   logic       o_recv_dat;
   logic       o_recv_sclr;
   logic       o_key_valid;
   logic [7:0] o_key_code;
   logic       o_key_ext;
   logic       o_key_break;
   logic       o_err;

   modport master (
      input  i_byte_en, i_byte,
      output o_recv_en, o_recv_dat, o_recv_sclr,
      output o_key_valid, o_key_code, o_key_ext, o_key_break, o_err
   );

   modport slave (
      output i_byte_en, i_byte,
      input  o_recv_en, o_recv_dat, o_recv_sclr,
      input  o_key_valid, o_key_code, o_key_ext, o_key_break, o_err
   );
endinterface

// File: rtl/kb_rx_ctrl.sv
// kb_rx_ctrl -- PS/2 receive sequencing: line synchronisers, per-bit enable
// to the frame receiver, frame watchdog with receiver clear, and E0/F0
// prefix assembly into one key event per make/break.
module kb_rx_ctrl #(
   parameter int TIMEOUT_CYCLES = 5000,
   parameter int CNT_W          = 16
) (
   input  logic         clk,
   input  logic         i_rst_n,
   input  logic         i_ps2_clk,
   input  logic         i_ps2_dat,
   kb_rx_ctrl_if.master bus
);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_EXT     = 2'd1,
      S_BRK     = 2'd2,
      S_EXT_BRK = 2'd3
   } state_t;

   localparam logic [7:0]       PFX_EXT  = 8'hE0;
   localparam logic [7:0]       PFX_BRK  = 8'hF0;
   localparam logic [3:0]       STOP_IDX = 4'd10;
   localparam logic [CNT_W-1:0] WD_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);

   // line synchronisers and edge stage
   logic             r_clk_s1, r_clk_s2, r_clk_prev;
   logic             r_dat_s1, r_dat_s2;
   logic             r_recv_en, r_recv_dat;
   // frame supervision
   logic [3:0]       r_bit_cnt;
   logic [3:0]       w_bit_cnt_nxt;
   logic [CNT_W-1:0] r_wd;
   logic             r_byte_seen;
   logic             r_recv_sclr, r_err;
   // byte handshake and decode
   logic             r_byte_en_d, r_cap_pend;
   state_t           r_state, w_state_nxt;
   logic             w_emit, w_ext, w_brk;
   logic             r_key_valid, r_key_ext, r_key_brk;
   logic [7:0]       r_key_code;

   logic w_fall, w_start, w_stop, w_byte_rise;
   logic w_frame_err, w_timeout, w_clear;

   assign w_fall      = r_clk_prev & ~r_clk_s2;
   assign w_start     = r_recv_en & (r_bit_cnt == 4'd0) & ~r_recv_dat;
   assign w_stop      = r_recv_en & (r_bit_cnt == STOP_IDX);
   assign w_byte_rise = bus.i_byte_en & ~r_byte_en_d;
   // A byte_en rise landing on the stop edge itself still counts as delivered.
   assign w_frame_err = w_stop & ~(r_byte_seen | w_byte_rise);
   assign w_timeout   = (r_bit_cnt != 4'd0) & ~r_recv_en & (r_wd == WD_LAST);
   assign w_clear     = w_timeout | w_frame_err;

   // Synchronise both lines; flops reset high so reset release is not an edge.
   always_ff @(posedge clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_clk_s1   <= 1'b1;
         r_clk_s2   <= 1'b1;
         r_clk_prev <= 1'b1;
         r_dat_s1   <= 1'b1;
         r_dat_s2   <= 1'b1;
      end else begin
         // NOTE: non-blocking assignments make each flop take the pre-edge value of its source, so this is a real shift chain and not one wire.
         r_clk_s1   <= i_ps2_clk;
         r_clk_s2   <= r_clk_s1;
         r_clk_prev <= r_clk_s2;
         r_dat_s1   <= i_ps2_dat;
         r_dat_s2   <= r_dat_s1;
      end
   end

   // Register the falling edge as the bit enable; an edge colliding with expiry is dropped.
   always_ff @(posedge clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_recv_en  <= 1'b0;
         r_recv_dat <= 1'b0;
      end else begin
         r_recv_en  <= w_fall & ~w_timeout;
         r_recv_dat <= r_dat_s2;
      end
   end

   // Next bit position: idle until a 0 start bit, wrap after the stop bit.
   always_comb begin
      // NOTE: assigning the default first means every path writes the signal, so no latch is inferred.
      w_bit_cnt_nxt = r_bit_cnt;
      if (w_timeout) begin
         w_bit_cnt_nxt = 4'd0;
      end else if (r_recv_en) begin
         if (r_bit_cnt == 4'd0) begin
            w_bit_cnt_nxt = r_recv_dat ? 4'd0 : 4'd1;
         end else if (r_bit_cnt == STOP_IDX) begin
            w_bit_cnt_nxt = 4'd0;
         end else begin
            w_bit_cnt_nxt = r_bit_cnt + 4'd1;
         end
      end
   end

   // Bit counter and inter-edge watchdog; the watchdog only runs inside a frame.
   always_ff @(posedge clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_bit_cnt <= 4'd0;
         r_wd      <= '0;
      end else begin
         r_bit_cnt <= w_bit_cnt_nxt;
         if (w_bit_cnt_nxt == 4'd0) begin
            r_wd <= '0;
         end else if (r_recv_en) begin
            // The cycle after an enable is the first cycle since that edge.
            r_wd <= CNT_W'(1);
         end else begin
            r_wd <= r_wd + CNT_W'(1);
         end
      end
   end

   // Remember whether the receiver delivered a byte since the current start bit.
   always_ff @(posedge clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_byte_seen <= 1'b0;
      end else if (w_byte_rise) begin
         r_byte_seen <= 1'b1;
      end else if (w_start) begin
         r_byte_seen <= 1'b0;
      end
   end

   // Receiver clear and error strobe; clear is also held through reset and its first cycle.
   always_ff @(posedge clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_recv_sclr <= 1'b1;
         r_err       <= 1'b0;
      end else begin
         r_recv_sclr <= w_clear;
         r_err       <= w_clear;
      end
   end

   // Detect the byte_en rise and schedule the byte capture for the following cycle.
   always_ff @(posedge clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_byte_en_d <= 1'b0;
         r_cap_pend  <= 1'b0;
      end else begin
         r_byte_en_d <= bus.i_byte_en;
         r_cap_pend  <= w_byte_rise;
      end
   end

   // Decode state register.
   always_ff @(posedge clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Prefix decode of the captured byte; a same-cycle clear discards it.
   always_comb begin
      w_state_nxt = r_state;
      w_emit      = 1'b0;
      w_ext       = 1'b0;
      w_brk       = 1'b0;
      if (r_cap_pend) begin
         unique case (r_state)
            S_IDLE: begin
               if (bus.i_byte == PFX_EXT) begin
                  w_state_nxt = S_EXT;
               end else if (bus.i_byte == PFX_BRK) begin
                  w_state_nxt = S_BRK;
               end else begin
                  w_emit = 1'b1;
               end
            end
            S_EXT: begin
               if (bus.i_byte == PFX_BRK) begin
                  w_state_nxt = S_EXT_BRK;
               end else if (bus.i_byte != PFX_EXT) begin
                  w_emit      = 1'b1;
                  w_ext       = 1'b1;
                  w_state_nxt = S_IDLE;
               end
            end
            S_BRK: begin
               w_emit      = 1'b1;
               w_brk       = 1'b1;
               w_state_nxt = S_IDLE;
            end
            S_EXT_BRK: begin
               w_emit      = 1'b1;
               w_ext       = 1'b1;
               w_brk       = 1'b1;
               w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
         endcase
      end
      if (w_clear) begin
         w_state_nxt = S_IDLE;
         w_emit      = 1'b0;
      end
   end

   // Key event register: fields hold between events, only the valid strobe pulses.
   always_ff @(posedge clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_key_valid <= 1'b0;
         r_key_code  <= 8'h00;
         r_key_ext   <= 1'b0;
         r_key_brk   <= 1'b0;
      end else begin
         r_key_valid <= w_emit;
         if (w_emit) begin
            r_key_code <= bus.i_byte;
            r_key_ext  <= w_ext;
            r_key_brk  <= w_brk;
         end
      end
   end

   assign bus.o_recv_en   = r_recv_en;
   assign bus.o_recv_dat  = r_recv_dat;
   assign bus.o_recv_sclr = r_recv_sclr;
   assign bus.o_err       = r_err;
   assign bus.o_key_valid = r_key_valid;
   assign bus.o_key_code  = r_key_code;
   assign bus.o_key_ext   = r_key_ext;
   assign bus.o_key_break = r_key_brk;

endmodule

// File: doc/kb_rx_ctrl.md
Name: kb_rx_ctrl

Overview:
- Sequencing controller for the PS/2 frame receiver (`recv`) and scan-code front end of the keyboard path.
- Synchronises the raw PS/2 clock/data lines and generates the receiver's per-bit enable.
- Supervises frame timing with a bit counter and inter-edge watchdog, clearing the receiver on stall or framing loss.
- Assembles received bytes (E0/F0 prefixes) into one key event per key make/break for downstream logic.

Parameters:
- TIMEOUT_CYCLES, 5000: max clk cycles allowed between PS/2 falling edges inside a frame.
- CNT_W, 16: watchdog counter width. Must hold TIMEOUT_CYCLES.

Ports:
- clk  in  1  system clock.
- i_rst_n  in  1  asynchronous active-low reset.
- i_ps2_clk  in  1  raw PS/2 clock line (asynchronous).
- i_ps2_dat  in  1  raw PS/2 data line (asynchronous).
- i_byte_en  in  1  receiver byte-complete flag. Level; may stay high many cycles.
- i_byte  in  8  receiver byte. Valid from the cycle after i_byte_en rises.
- o_recv_en  out  1  one-cycle bit-sample enable to receiver.
- o_recv_dat  out  1  synchronised data bit, aligned with o_recv_en.
- o_recv_sclr  out  1  synchronous clear to receiver.
- o_key_valid  out  1  one-cycle key-event strobe.
- o_key_code  out  8  scan code (prefixes stripped).
- o_key_ext  out  1  event had E0 prefix.
- o_key_break  out  1  event is a release (F0 prefix).
- o_err  out  1  one-cycle strobe on timeout or frame error.

Behaviour:
- Reset (async, i_rst_n=0):
  - Synchroniser flops and previous-clock flop = 1 (idle-high lines; no spurious edge at release).
  - o_recv_sclr = 1 during reset and for the first clk after release, then 0.
  - All other outputs, counters and FSM = 0 / S_IDLE.
- Synchroniser and edge detect:
  - 2-flop synchronisers on both PS/2 lines.
  - Falling edge = sync_clk 1→0, registered.
  - o_recv_en high exactly one cycle per falling edge.
  - o_recv_dat = synchronised data sampled in the same stage. Latency from line edge to o_recv_en: 3 clk.
- Bit counter, 0..10:
  - Increments on each o_recv_en.
  - At count 0, an edge with o_recv_dat=1 is ignored (no start bit); count stays 0.
  - After the 11th edge (stop bit), count returns to 0.
- Byte handshake:
  - Rising edge of i_byte_en is detected at cycle T.
  - i_byte is captured at T+1.
  - Decode result is registered; o_key_valid (if any) is asserted at T+2.
  - Further cycles with i_byte_en held high are ignored.
- Frame error:
  - Stop-bit edge (11th) with no i_byte_en rise seen since the start bit (receiver dropped the frame, e.g. parity) → o_err pulse.
  - o_recv_sclr pulse for 1 cycle; decode FSM → S_IDLE.
- Watchdog:
  - Counts cycles while bit count ≠ 0; cleared on every o_recv_en.
  - On reaching TIMEOUT_CYCLES: o_recv_sclr and o_err pulse 1 cycle; bit count → 0; decode FSM → S_IDLE; watchdog → 0.
  - Idle at count 0: watchdog held at 0, never fires.
- Decode FSM, states S_IDLE, S_EXT, S_BRK, S_EXT_BRK:
  - S_IDLE: E0→S_EXT; F0→S_BRK; other→emit (code, ext=0, break=0), stay.
  - S_EXT: F0→S_EXT_BRK; E0→stay; other→emit (code, ext=1, break=0), →S_IDLE.
  - S_BRK: any byte→emit (code, ext=0, break=1), →S_IDLE.
  - S_EXT_BRK: any byte→emit (code, ext=1, break=1), →S_IDLE.
  - Emitted fields hold until the next event; only o_key_valid pulses.
- Simultaneous events:
  - Timeout/frame-error clear in the same cycle as a byte capture → clear wins; no event emitted; FSM → S_IDLE.
  - A falling edge in the same cycle the watchdog expires is dropped.

Test Plan:
- Frame for 0x1C (start 0, LSB-first data, odd parity 0, stop 1) at 10 kHz PS/2 clock → 11 o_recv_en pulses; o_key_valid once with code=0x1C, ext=0, break=0; o_err=0.
- Bytes F0, 1C → single event code=0x1C, break=1, ext=0; no event on F0.
- Bytes E0, F0, 75 → single event code=0x75, ext=1, break=1. Then E0, 75 → ext=1, break=0.
- Stop PS/2 clock after 4 edges for >TIMEOUT_CYCLES → o_recv_sclr and o_err pulse once at exactly TIMEOUT_CYCLES after the last o_recv_en; next valid frame decodes correctly.
- Frame with wrong parity (receiver drops it) → o_err at stop edge; no o_key_valid. Pending F0 prefix is discarded (next 1C reports break=0).
- Assert i_rst_n=0 mid-frame (after 6 edges) → outputs zero and o_recv_sclr=1 immediately; after release, a full 0x29 frame decodes as code=0x29.
